// File: rtl/qclk_pkg.sv
// rtl/qclk_pkg.sv - shared command word layout for the core and the command buffer
package qclk_pkg;
    localparam int CMD_WIDTH     = 128;
    localparam int TIME_WIDTH    = 24;
    localparam int TIME_LSB      = CMD_WIDTH - TIME_WIDTH;
    localparam int PAYLOAD_WIDTH = CMD_WIDTH - TIME_WIDTH;

    typedef struct packed {
        logic [TIME_WIDTH-1:0]    cmd_time;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } cmd_word_t;
endpackage

// File: rtl/qclk_cmd_buffer_if.sv
// rtl/qclk_cmd_buffer_if.sv - command in / pulse out signal bundle between core and buffer
interface qclk_cmd_buffer_if #(
    parameter int CMD_WIDTH  = qclk_pkg::CMD_WIDTH,
    parameter int TIME_WIDTH = qclk_pkg::TIME_WIDTH
);
    logic [CMD_WIDTH-1:0]            cmd_in;
    logic                            cstrobe_in;
    logic [CMD_WIDTH-TIME_WIDTH-1:0] payload_out;
    logic                            pulse_strobe;

    modport master (output cmd_in, output cstrobe_in, input payload_out, input pulse_strobe);
    modport slave  (input cmd_in, input cstrobe_in, output payload_out, output pulse_strobe);
endinterface

// File: rtl/qclk_cmd_buffer_cmd_fifo.sv
// rtl/qclk_cmd_buffer_cmd_fifo.sv - show-ahead synchronous FIFO with flush
module cmd_fifo #(
    parameter int WIDTH      = 128,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees the slot a write into a full FIFO needs.
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                rptr <= rptr + ADDR_WIDTH'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (ADDR_WIDTH+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (ADDR_WIDTH+1)'(1);
            end
        end
    end
endmodule

// File: rtl/qclk_cmd_buffer.sv
// rtl/qclk_cmd_buffer.sv - timestamped command queue released against the quantum-clock counter
module qclk_cmd_buffer
    import qclk_pkg::*;
#(
    parameter int CMD_WIDTH       = qclk_pkg::CMD_WIDTH,
    parameter int TIME_WIDTH      = qclk_pkg::TIME_WIDTH,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  qclk_rst,
    qclk_cmd_buffer_if.slave      bus,
    output logic [TIME_WIDTH-1:0] qclk,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  late
);
    localparam int PW = CMD_WIDTH - TIME_WIDTH;

    logic [CMD_WIDTH-1:0]  head;
    logic [TIME_WIDTH-1:0] head_time;
    logic [TIME_WIDTH-1:0] diff;
    logic                  due;
    logic [PW-1:0]         payload_q;
    logic                  strobe_q;

    assign head_time = head[CMD_WIDTH-1:PW];
    assign diff      = qclk - head_time;
    // Modular distance: MSB clear means the head time is now or at most half a range behind.
    assign due       = !empty && enable && !qclk_rst && !diff[TIME_WIDTH-1];

    cmd_fifo #(
        .WIDTH      (CMD_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (bus.cstrobe_in),
        .pop   (due),
        .flush (qclk_rst),
        .din   (bus.cmd_in),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.payload_out  = payload_q;
    assign bus.pulse_strobe = strobe_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qclk      <= '0;
            payload_q <= '0;
            strobe_q  <= 1'b0;
            overflow  <= 1'b0;
            late      <= 1'b0;
        end else begin
            if (qclk_rst) begin
                qclk <= '0;
            end else if (enable) begin
                qclk <= qclk + TIME_WIDTH'(1);
            end
            strobe_q <= due;
            if (due) begin
                payload_q <= head[PW-1:0];
            end
            if (due && (diff != '0)) begin
                late <= 1'b1;
            end
            // Flushed writes are discarded silently; only a genuine full drop counts.
            if (bus.cstrobe_in && full && !due && !qclk_rst) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qclk_cmd_buffer.sv
// tb/tb_qclk_cmd_buffer.sv - directed bench with queue-based release model for qclk_cmd_buffer
module tb_qclk_cmd_buffer;
    localparam int CW    = 128;
    localparam int TW    = 12;
    localparam int AW    = 4;
    localparam int PW    = CW - TW;
    localparam int DEPTH = 16;
    localparam int RANGE = 1 << TW;
    localparam int HALF  = 1 << (TW - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          qclk_rst = 1'b0;
    logic [TW-1:0] qclk;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          late;

    qclk_cmd_buffer_if #(.CMD_WIDTH(CW), .TIME_WIDTH(TW)) bus ();

    qclk_cmd_buffer #(.CMD_WIDTH(CW), .TIME_WIDTH(TW), .FIFO_ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .qclk_rst (qclk_rst),
        .bus      (bus),
        .qclk     (qclk),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .late     (late)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a list of pending commands and a free-running time value.
    logic [CW-1:0] m_q[$];
    logic [TW-1:0] m_qclk = '0;
    logic [PW-1:0] m_payload = '0;
    logic          m_strobe = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_late = 1'b0;
    logic [CW-1:0] m_head;
    int            m_dist;
    bit            m_rel;
    bit            m_was_full;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_qclk = '0; m_payload = '0; m_strobe = 1'b0; m_ovf = 1'b0; m_late = 1'b0;
        end else begin
            m_rel = 0;
            m_was_full = (m_q.size() == DEPTH);
            if (m_q.size() > 0 && enable && !qclk_rst) begin
                m_head = m_q[0];
                m_dist = (int'(m_qclk) - int'(m_head[CW-1:PW]) + RANGE) % RANGE;
                if (m_dist < HALF) begin
                    m_rel = 1;
                    m_payload = m_head[PW-1:0];
                    if (m_dist != 0) m_late = 1'b1;
                    void'(m_q.pop_front());
                end
            end
            m_strobe = m_rel;
            if (qclk_rst) begin
                m_q.delete();
            end else if (bus.cstrobe_in) begin
                if (m_was_full && !m_rel) m_ovf = 1'b1;
                else m_q.push_back(bus.cmd_in);
            end
            if (qclk_rst) m_qclk = '0;
            else if (enable) m_qclk = TW'((int'(m_qclk) + 1) % RANGE);
        end
    end

    typedef struct {
        int            q;
        logic [PW-1:0] p;
        logic          lt;
    } seen_t;
    seen_t seen[$];

    always @(negedge clk) begin
        check("qclk", 128'(qclk), 128'(m_qclk));
        check("empty", 128'(empty), 128'(m_q.size() == 0));
        check("full", 128'(full), 128'(m_q.size() == DEPTH));
        check("overflow", 128'(overflow), 128'(m_ovf));
        check("late", 128'(late), 128'(m_late));
        check("pulse_strobe", 128'(bus.pulse_strobe), 128'(m_strobe));
        check("payload_out", 128'(bus.payload_out), 128'(m_payload));
        if (bus.pulse_strobe === 1'b1) seen.push_back('{q: int'(qclk), p: bus.payload_out, lt: late});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_qclk(input int v, input int budget);
        int k = 0;
        while (int'(qclk) != v && k < budget) begin
            tick(1);
            k++;
        end
        check("wait_qclk", 128'(qclk), 128'(v));
    endtask

    task automatic write_cmd(input int t, input int p);
        bus.cmd_in = {TW'(t), PW'(p)};
        bus.cstrobe_in = 1'b1;
        tick(1);
        bus.cstrobe_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        seen.delete();
    endtask

    initial begin
        int k;
        bus.cmd_in = '0;
        bus.cstrobe_in = 1'b0;
        tick(2);
        check("rst_qclk", 128'(qclk), 128'(0));
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_full", 128'(full), 128'(0));
        check("rst_strobe", 128'(bus.pulse_strobe), 128'(0));
        reset = 1'b1;
        enable = 1'b1;

        // On-time release
        wait_qclk(3, 20);
        write_cmd(10, 'hAB);
        tick(12);
        check("t1_count", 128'(seen.size()), 128'(1));
        check("t1_qclk", 128'(seen[0].q), 128'(11));
        check("t1_payload", 128'(seen[0].p), 128'('hAB));
        check("t1_late", 128'(late), 128'(0));

        // Late release
        qclk_rst = 1'b1;
        tick(1);
        qclk_rst = 1'b0;
        seen.delete();
        wait_qclk(5, 20);
        write_cmd(2, 'h2C);
        tick(5);
        check("t2_count", 128'(seen.size()), 128'(1));
        check("t2_qclk", 128'(seen[0].q), 128'(7));
        check("t2_payload", 128'(seen[0].p), 128'('h2C));
        check("t2_late", 128'(late), 128'(1));

        // Equal timestamps release in order on consecutive cycles
        do_reset();
        for (int i = 1; i <= 3; i++) write_cmd(20, i);
        tick(25);
        check("t3_count", 128'(seen.size()), 128'(3));
        for (int i = 0; i < 3; i++) begin
            check("t3_qclk", 128'(seen[i].q), 128'(21 + i));
            check("t3_payload", 128'(seen[i].p), 128'(i + 1));
        end
        check("t3_late0", 128'(seen[0].lt), 128'(0));
        check("t3_late1", 128'(seen[1].lt), 128'(1));

        // Overflow
        enable = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) write_cmd(100, i);
        check("t4_full", 128'(full), 128'(1));
        check("t4_ovf_before", 128'(overflow), 128'(0));
        write_cmd(100, 16);
        check("t4_ovf", 128'(overflow), 128'(1));
        enable = 1'b1;
        tick(130);
        check("t4_count", 128'(seen.size()), 128'(16));
        check("t4_first_q", 128'(seen[0].q), 128'(101));
        check("t4_last_q", 128'(seen[15].q), 128'(116));
        check("t4_last_p", 128'(seen[15].p), 128'(15));

        // Counter wrap and a far-ahead entry
        do_reset();
        wait_qclk(RANGE - 3, RANGE + 10);
        write_cmd(1, 'h55);
        write_cmd(HALF + 2, 'h66);
        wait_qclk(200, 400);
        check("t5_count", 128'(seen.size()), 128'(1));
        check("t5_qclk", 128'(seen[0].q), 128'(2));
        check("t5_late", 128'(seen[0].lt), 128'(0));
        wait_qclk(HALF + 5, HALF + 10);
        check("t5_count2", 128'(seen.size()), 128'(2));
        check("t5_qclk2", 128'(seen[1].q), 128'(HALF + 3));
        check("t5_payload2", 128'(seen[1].p), 128'('h66));

        // qclk_rst flush keeps sticky flags
        do_reset();
        write_cmd(0, 'h77);
        for (int i = 0; i < 4; i++) write_cmd(500, 'h80 + i);
        tick(2);
        check("t6_late_pre", 128'(late), 128'(1));
        check("t6_empty_pre", 128'(empty), 128'(0));
        seen.delete();
        qclk_rst = 1'b1;
        bus.cmd_in = {TW'(3), PW'('h99)};
        bus.cstrobe_in = 1'b1;
        tick(1);
        qclk_rst = 1'b0;
        bus.cstrobe_in = 1'b0;
        check("t6_qclk", 128'(qclk), 128'(0));
        check("t6_empty", 128'(empty), 128'(1));
        check("t6_strobe", 128'(bus.pulse_strobe), 128'(0));
        check("t6_late", 128'(late), 128'(1));
        check("t6_ovf", 128'(overflow), 128'(0));
        tick(600);
        check("t6_count", 128'(seen.size()), 128'(0));

        // Asynchronous reset while a strobe is high
        do_reset();
        write_cmd(4, 'h99);
        k = 0;
        while (bus.pulse_strobe !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        check("t7_strobe_hi", 128'(bus.pulse_strobe), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check("t7_strobe_lo", 128'(bus.pulse_strobe), 128'(0));
        check("t7_qclk", 128'(qclk), 128'(0));
        check("t7_payload", 128'(bus.payload_out), 128'(0));
        tick(1);
        reset = 1'b1;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/qclk_cmd_buffer.md
Name: qclk_cmd_buffer

Overview:
- Downstream stage of the distributed processor core.
- Captures each command the core issues on its command output with its command strobe, and queues it in a small FIFO.
- Releases each command's payload to the pulse/element interface when the local quantum-clock counter reaches the command's timestamp.
- Decouples the core's instruction timing from exact pulse timing. Reports overflow and late-release errors as sticky flags.

Parameters:
- CMD_WIDTH, 128, full command word width; matches the core's command output.
- TIME_WIDTH, 24, timestamp field width; occupies bits [CMD_WIDTH-1 : CMD_WIDTH-TIME_WIDTH].
- FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH = 16 entries.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run enable; gates qclk increment and release.
- qclk_rst  in  1  synchronous clear of qclk to 0; also flushes the FIFO.
- cmd_in  in  CMD_WIDTH  command word from the core.
- cstrobe_in  in  1  one-cycle write strobe for cmd_in.
- payload_out  out  CMD_WIDTH-TIME_WIDTH  released payload (command with timestamp stripped).
- pulse_strobe  out  1  one-cycle strobe qualifying payload_out.
- qclk  out  TIME_WIDTH  current time counter.
- full  out  1  FIFO holds 2**FIFO_ADDR_WIDTH entries.
- empty  out  1  FIFO holds 0 entries.
- overflow  out  1  sticky: a write was dropped.
- late  out  1  sticky: a command was released after its timestamp.

Behaviour:
- Reset (reset=0, async):
  - qclk=0, FIFO empty (pointers and count 0).
  - payload_out=0, pulse_strobe=0, overflow=0, late=0.
  - Therefore empty=1 and full=0.
- qclk:
  - When qclk_rst=1, qclk becomes 0 next edge. This has priority over enable.
  - Otherwise, when enable=1, qclk increments by 1 per clk, wrapping modulo 2**TIME_WIDTH.
  - When enable=0, qclk holds.
- Write:
  - cstrobe_in=1 pushes cmd_in at the edge.
  - If full=1 and no pop occurs that cycle, the write is dropped and overflow sets. overflow stays set until reset.
  - If full=1 with a simultaneous pop, the write is accepted and count is unchanged.
  - A written entry is visible at the head no earlier than the following cycle. There is no write-to-head bypass.
- Release condition, evaluated combinationally on the head entry each cycle:
  - Requires empty=0 and enable=1 and qclk_rst=0.
  - diff = (qclk - head_time) mod 2**TIME_WIDTH.
  - due = (diff MSB == 0), i.e. the head time is reached or passed within half the counter range.
- Release action:
  - When due, pop the head.
  - Next edge: pulse_strobe=1 and payload_out = head[CMD_WIDTH-TIME_WIDTH-1:0].
  - If diff != 0, late also sets (sticky).
  - Latency: a command with timestamp T is strobed on the cycle after qclk==T, provided it was at the head by then.
  - At most one release per cycle. Back-to-back equal timestamps release on consecutive cycles; the second one sets late.
- payload_out holds its last value when pulse_strobe=0. pulse_strobe is a single-cycle pulse.
- A head with diff MSB=1 (far future, or more than half a range late) waits and blocks later entries. Strict in-order release; no reordering.
- qclk_rst=1:
  - Flushes the FIFO: pointers cleared next edge, and any cstrobe_in that cycle is dropped without setting overflow.
  - No release that cycle.
  - overflow and late are not cleared.
- enable=0: no release; writes are still accepted.
- Mid-operation reset: all state returns to reset values immediately, regardless of clk.
- FIFO count is FIFO_ADDR_WIDTH+1 bits wide, for an unambiguous full/empty decision.

Decomposition:
- Shared package qclk_pkg holds:
  - field offsets TIME_LSB = CMD_WIDTH-TIME_WIDTH and PAYLOAD_WIDTH;
  - a cmd_word typedef with time and payload fields.
- The core and this block both import it.
- Sub-module cmd_fifo is a synchronous FIFO with:
  - parameters WIDTH and ADDR_WIDTH;
  - ports push, pop, flush, din, dout (head, show-ahead), full, empty.
- The top level holds qclk, release compare, output register and sticky flags.

Test Plan:
- Reset then enable=1; write cmd time=10, payload=0xAB at qclk=3 -> pulse_strobe=1 exactly once, on the cycle after qclk==10; payload_out=0xAB; late=0.
- Write time=2 when qclk=5 -> released on the next eligible cycle; late=1; payload correct.
- Write 3 cmds with time=20 -> strobes at qclk 21, 22, 23 in write order; late=1 after the second.
- 17 writes with time=100 at qclk=0 (no pops) -> full=1 after the 16th; 17th dropped; overflow=1; exactly 16 strobes later.
- qclk near wrap (set by running to 2**24-3), write time=1 -> release after wrap at qclk==1, late=0; a time 2**23+5 ahead is not released early.
- With 4 queued entries, pulse qclk_rst -> qclk=0, empty=1, no strobe, overflow/late unchanged. Async reset asserted mid-release -> pulse_strobe=0 immediately.
